// File: rtl/uart_tx_buffered_pkg.sv
// Shared definitions for the buffered UART transmitter (also usable by an rx side).
//  - parity-mode constants UART_PAR_NONE / EVEN / ODD
//  - transmit FSM state encoding UART_ST_*
//  - parity_of(): parity bit of a word (up to 9 bits, zero-padded) for a given mode
package uart_tx_buffered_pkg;

    localparam int UART_PAR_NONE = 0;
    localparam int UART_PAR_EVEN = 1;
    localparam int UART_PAR_ODD  = 2;

    typedef enum logic [2:0] {
        UART_ST_IDLE   = 3'd0,
        UART_ST_START  = 3'd1,
        UART_ST_DATA   = 3'd2,
        UART_ST_PARITY = 3'd3,
        UART_ST_STOP   = 3'd4
    } uart_state_e;

    // Zero padding of narrower words does not change the XOR reduction.
    function automatic logic parity_of(input logic [8:0] word, input int mode);
        return (mode == UART_PAR_ODD) ? ~(^word) : ^word;
    endfunction

endpackage

// File: rtl/uart_tx_fifo.sv
// Synchronous FIFO feeding the UART transmitter.
//  clock      in   rising-edge clock
//  reset      in   asynchronous, active-low; empties the FIFO
//  push       in   write push_data (ignored while full)
//  push_data  in   WIDTH-bit word to store
//  pop        in   discard the head entry (ignored while empty)
//  head       out  current head entry (valid while !empty)
//  count      out  occupied entries, 0..DEPTH
//  full/empty out  status flags
// DEPTH must be a power of two so the pointers wrap by plain overflow.
module uart_tx_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic                     push,
    input  logic [WIDTH-1:0]         push_data,
    input  logic                     pop,
    output logic [WIDTH-1:0]         head,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     full,
    output logic                     empty
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign full    = (count == FULL_CNT);
    assign empty   = (count == '0);
    assign do_push = push & ~full;
    assign do_pop  = pop & ~empty;
    assign head    = mem[rd_ptr];

    // Storage carries no reset; only the pointers and count define contents.
    always_ff @(posedge clock) begin
        if (do_push) mem[wr_ptr] <= push_data;
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + AW'(1);
            if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
            case ({do_push, do_pop})
                2'b10:   count <= count + (AW+1)'(1);
                2'b01:   count <= count - (AW+1)'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/uart_tx_buffered.sv
// Buffered UART transmitter: queued words are framed as
// START(0), DATA_BITS data LSB first, optional parity, STOP_BITS x 1,
// each cell CLKS_PER_BIT clocks, frames sent back-to-back while the FIFO has data.
//  clock       in   rising-edge clock
//  reset       in   asynchronous, active-low
//  tx_data     in   word to queue
//  tx_valid    in   tx_data valid; written when tx_ready is also high
//  tx_ready    out  FIFO has room
//  fifo_count  out  occupied FIFO entries
//  tx_busy     out  high while any frame cell is driven
//  Serial_out  out  registered serial line, idle high
module uart_tx_buffered
    import uart_tx_buffered_pkg::*;
#(
    parameter int DATA_BITS    = 8,
    parameter int CLKS_PER_BIT = 16,
    parameter int FIFO_DEPTH   = 4,
    parameter int PARITY       = 0,
    parameter int STOP_BITS    = 1
) (
    input  logic                          clock,
    input  logic                          reset,
    input  logic [DATA_BITS-1:0]          tx_data,
    input  logic                          tx_valid,
    output logic                          tx_ready,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
    output logic                          tx_busy,
    output logic                          Serial_out
);

    generate
        if (DATA_BITS < 5 || DATA_BITS > 9) begin : g_bad_data_bits
            $error("uart_tx_buffered: DATA_BITS must be 5..9");
        end
        if (CLKS_PER_BIT < 2) begin : g_bad_clks
            $error("uart_tx_buffered: CLKS_PER_BIT must be >= 2");
        end
        if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_bad_depth
            $error("uart_tx_buffered: FIFO_DEPTH must be a power of two >= 2");
        end
        if (PARITY < 0 || PARITY > 2) begin : g_bad_parity
            $error("uart_tx_buffered: PARITY must be 0, 1 or 2");
        end
        if (STOP_BITS < 1 || STOP_BITS > 2) begin : g_bad_stop
            $error("uart_tx_buffered: STOP_BITS must be 1 or 2");
        end
    endgenerate

    localparam int BW = $clog2(CLKS_PER_BIT);
    localparam int IW = $clog2(DATA_BITS);
    localparam logic [BW-1:0] BAUD_LAST  = BW'(CLKS_PER_BIT - 1);
    localparam logic [IW-1:0] BIT_LAST   = IW'(DATA_BITS - 1);
    localparam logic          STOP_LAST  = 1'(STOP_BITS - 1);
    localparam bit            HAS_PARITY = (PARITY != UART_PAR_NONE);

    uart_state_e          state;
    logic [BW-1:0]        baud_cnt;
    logic [IW-1:0]        bit_idx;
    logic [IW-1:0]        next_idx;
    logic                 stop_idx;
    logic [DATA_BITS-1:0] word;
    logic [DATA_BITS-1:0] head;
    logic                 fifo_full;
    logic                 fifo_empty;
    logic                 cell_end;
    logic                 stop_done;
    logic                 pop;
    logic                 parity_bit;

    uart_tx_fifo #(
        .WIDTH (DATA_BITS),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clock     (clock),
        .reset     (reset),
        .push      (tx_valid),
        .push_data (tx_data),
        .pop       (pop),
        .head      (head),
        .count     (fifo_count),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );

    assign tx_ready   = ~fifo_full;
    assign cell_end   = (baud_cnt == BAUD_LAST);
    assign stop_done  = (stop_idx == STOP_LAST);
    assign next_idx   = bit_idx + IW'(1);
    assign parity_bit = parity_of(9'(word), PARITY);

    // Head leaves the FIFO either from idle or at the end of the last stop
    // cell, so consecutive frames abut with no idle cell between them.
    assign pop = ~fifo_empty &
                 ((state == UART_ST_IDLE) |
                  ((state == UART_ST_STOP) & cell_end & stop_done));

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state      <= UART_ST_IDLE;
            baud_cnt   <= '0;
            bit_idx    <= '0;
            stop_idx   <= 1'b0;
            word       <= '0;
            tx_busy    <= 1'b0;
            Serial_out <= 1'b1;
        end else begin
            // Every state leaves on cell_end, so wrapping here also restarts
            // the counter on each state entry.
            if (state == UART_ST_IDLE || cell_end) baud_cnt <= '0;
            else                                   baud_cnt <= baud_cnt + BW'(1);

            case (state)
                UART_ST_IDLE: begin
                    if (pop) begin
                        word       <= head;
                        state      <= UART_ST_START;
                        tx_busy    <= 1'b1;
                        Serial_out <= 1'b0;
                    end
                end
                UART_ST_START: begin
                    if (cell_end) begin
                        state      <= UART_ST_DATA;
                        bit_idx    <= '0;
                        Serial_out <= word[0];
                    end
                end
                UART_ST_DATA: begin
                    if (cell_end) begin
                        if (bit_idx == BIT_LAST) begin
                            if (HAS_PARITY) begin
                                state      <= UART_ST_PARITY;
                                Serial_out <= parity_bit;
                            end else begin
                                state      <= UART_ST_STOP;
                                stop_idx   <= 1'b0;
                                Serial_out <= 1'b1;
                            end
                        end else begin
                            bit_idx    <= next_idx;
                            Serial_out <= word[next_idx];
                        end
                    end
                end
                UART_ST_PARITY: begin
                    if (cell_end) begin
                        state      <= UART_ST_STOP;
                        stop_idx   <= 1'b0;
                        Serial_out <= 1'b1;
                    end
                end
                UART_ST_STOP: begin
                    if (cell_end) begin
                        if (!stop_done) begin
                            stop_idx <= 1'b1;
                        end else if (pop) begin
                            word       <= head;
                            state      <= UART_ST_START;
                            Serial_out <= 1'b0;
                        end else begin
                            state      <= UART_ST_IDLE;
                            tx_busy    <= 1'b0;
                            Serial_out <= 1'b1;
                        end
                    end
                end
                default: begin
                    state      <= UART_ST_IDLE;
                    tx_busy    <= 1'b0;
                    Serial_out <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_tx_buffered.sv
// Bench for uart_tx_buffered: three configurations driven together.
//  inst 0: 8 data, no parity, 1 stop, 4 clk/bit, depth 4
//  inst 1: 8 data, even parity, 2 stop, 4 clk/bit, depth 4
//  inst 2: 5 data, odd parity, 1 stop, 3 clk/bit, depth 2
// The reference model keeps a word queue and, per active frame, the word and
// the clock offset into the frame; the expected line level is derived from the
// cell number (offset / clocks-per-bit).
module tb_uart_tx_buffered;

    localparam int DB  [3] = '{8, 8, 5};
    localparam int PAR [3] = '{0, 1, 2};
    localparam int SB  [3] = '{1, 2, 1};
    localparam int CPB [3] = '{4, 4, 3};
    localparam int DEP [3] = '{4, 4, 2};

    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic [2:0] v = '0;
    logic [7:0] d0 = '0;
    logic [7:0] d1 = '0;
    logic [4:0] d2 = '0;
    logic [2:0] rdy, busy, ser;
    logic [2:0] cnt0, cnt1;
    logic [1:0] cnt2;

    always #5 clock = ~clock;

    uart_tx_buffered #(.DATA_BITS(8), .CLKS_PER_BIT(4), .FIFO_DEPTH(4), .PARITY(0), .STOP_BITS(1)) dut0 (
        .clock(clock), .reset(reset), .tx_data(d0), .tx_valid(v[0]), .tx_ready(rdy[0]),
        .fifo_count(cnt0), .tx_busy(busy[0]), .Serial_out(ser[0]));
    uart_tx_buffered #(.DATA_BITS(8), .CLKS_PER_BIT(4), .FIFO_DEPTH(4), .PARITY(1), .STOP_BITS(2)) dut1 (
        .clock(clock), .reset(reset), .tx_data(d1), .tx_valid(v[1]), .tx_ready(rdy[1]),
        .fifo_count(cnt1), .tx_busy(busy[1]), .Serial_out(ser[1]));
    uart_tx_buffered #(.DATA_BITS(5), .CLKS_PER_BIT(3), .FIFO_DEPTH(2), .PARITY(2), .STOP_BITS(1)) dut2 (
        .clock(clock), .reset(reset), .tx_data(d2), .tx_valid(v[2]), .tx_ready(rdy[2]),
        .fifo_count(cnt2), .tx_busy(busy[2]), .Serial_out(ser[2]));

    int checks = 0;
    int errors = 0;

    // model state
    int din   [3];
    int mq    [3][8];
    int mhd   [3];
    int mcnt  [3];
    bit mbusy [3];
    int mword [3];
    int mt    [3];

    function automatic int frame_len(input int i);
        return (1 + DB[i] + ((PAR[i] != 0) ? 1 : 0) + SB[i]) * CPB[i];
    endfunction

    function automatic int m_line(input int i);
        int c;
        int p;
        if (!mbusy[i]) return 1;
        c = mt[i] / CPB[i];
        if (c == 0) return 0;
        if (c <= DB[i]) return (mword[i] >> (c - 1)) & 1;
        if (PAR[i] != 0 && c == DB[i] + 1) begin
            p = $countones(mword[i]) & 1;
            return (PAR[i] == 1) ? p : 1 - p;
        end
        return 1;
    endfunction

    function automatic int act_cnt(input int i);
        case (i)
            0:       return int'(cnt0);
            1:       return int'(cnt1);
            default: return int'(cnt2);
        endcase
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 3; i++) begin
            mhd[i] = 0; mcnt[i] = 0; mbusy[i] = 0; mt[i] = 0; mword[i] = 0;
        end
    endtask

    task automatic model_step(input int i);
        int  pre;
        bit  start;
        pre   = mcnt[i];
        start = 0;
        if (mbusy[i]) begin
            if (mt[i] == frame_len(i) - 1) begin
                if (pre > 0) start = 1;
                else         mbusy[i] = 0;
            end else begin
                mt[i]++;
            end
        end else if (pre > 0) begin
            start = 1;
        end
        if (start) begin
            mword[i] = mq[i][mhd[i]];
            mhd[i]   = (mhd[i] + 1) % 8;
            mcnt[i]--;
            mbusy[i] = 1;
            mt[i]    = 0;
        end
        if (v[i] && pre < DEP[i]) begin
            mq[i][(mhd[i] + mcnt[i]) % 8] = din[i];
            mcnt[i]++;
        end
    endtask

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic compare_all();
        for (int i = 0; i < 3; i++) begin
            check($sformatf("serial%0d", i), int'(ser[i]), m_line(i));
            check($sformatf("busy%0d", i), int'(busy[i]), int'(mbusy[i]));
            check($sformatf("count%0d", i), act_cnt(i), mcnt[i]);
            check($sformatf("ready%0d", i), int'(rdy[i]), (mcnt[i] < DEP[i]) ? 1 : 0);
        end
    endtask

    task automatic drive(input int i, input bit val, input int data);
        int m;
        m = data & ((1 << DB[i]) - 1);
        din[i] = m;
        v[i] = val;
        case (i)
            0:       d0 = 8'(m);
            1:       d1 = 8'(m);
            default: d2 = 5'(m);
        endcase
    endtask

    task automatic cycle();
        @(posedge clock);
        if (reset) for (int i = 0; i < 3; i++) model_step(i);
        @(negedge clock);
        compare_all();
    endtask

    // Called just after a falling edge: reset lands between clock edges.
    task automatic async_reset();
        #2 reset = 1'b0;
        #1 model_reset();
    endtask

    logic       l0 [64];
    logic       l1 [64];
    logic       l2 [64];
    logic       b0 [64];
    logic       b1 [64];
    logic [9:0] e0;
    logic [7:0] e2;
    int         nb;
    int         nz;

    initial begin
        model_reset();
        for (int i = 0; i < 3; i++) drive(i, 0, 0);
        #1 reset = 1'b0;

        // reset / idle
        @(negedge clock);
        @(negedge clock);
        compare_all();
        check("reset_serial", int'(ser[0]), 1);
        check("reset_ready", int'(rdy[0]), 1);
        check("reset_count", int'(cnt0), 0);
        check("reset_busy", int'(busy[0]), 0);
        reset = 1'b1;
        for (int k = 0; k < 4; k++) cycle();
        check("idle_serial", int'(ser[0]), 1);

        // single frame on every configuration
        drive(0, 1, 'h41); drive(1, 1, 'h41); drive(2, 1, 'h16);
        cycle();
        for (int i = 0; i < 3; i++) drive(i, 0, 0);
        for (int k = 0; k < 50; k++) begin
            cycle();
            l0[k] = ser[0]; l1[k] = ser[1]; l2[k] = ser[2];
            b0[k] = busy[0]; b1[k] = busy[1];
        end
        e0 = 10'b1010000010;
        check("start_one_edge_after_push", int'(l0[0]), 0);
        for (int c = 0; c < 10; c++) check($sformatf("8N1_cell%0d", c), int'(l0[4*c+2]), int'(e0[c]));
        check("8N1_busy_last", int'(b0[39]), 1);
        check("8N1_busy_drop", int'(b0[40]), 0);
        check("even_parity_41", int'(l1[38]), 0);
        check("stop1_cell", int'(l1[42]), 1);
        check("stop2_cell", int'(l1[46]), 1);
        check("8E2_busy_last", int'(b1[47]), 1);
        check("8E2_busy_drop", int'(b1[48]), 0);
        e2 = 8'b10101100;
        for (int c = 0; c < 8; c++) check($sformatf("5O1_cell%0d", c), int'(l2[3*c+1]), int'(e2[c]));

        drive(1, 1, 'h07);
        cycle();
        drive(1, 0, 0);
        for (int k = 0; k < 50; k++) begin
            cycle();
            l1[k] = ser[1];
        end
        check("even_parity_07", int'(l1[38]), 1);

        // FIFO fill, overflow drop, back-to-back frames
        nb = 0;
        for (int j = 0; j < 6; j++) begin
            drive(0, 1, (j < 5) ? ('h11 + j) : 'h99);
            cycle();
            if (busy[0]) nb++;
            if (j == 4) begin
                check("full_ready", int'(rdy[0]), 0);
                check("full_count", int'(cnt0), 4);
            end
            if (j == 5) check("drop_count", int'(cnt0), 4);
        end
        drive(0, 0, 0);
        for (int k = 0; k < 300; k++) begin
            cycle();
            if (busy[0]) nb++;
        end
        check("b2b_busy_cycles", nb, 200);

        // reset in the middle of data bit 3 with two words queued
        drive(0, 1, 'hA5); cycle();
        drive(0, 1, 'hB1); cycle();
        drive(0, 1, 'hC2); cycle();
        drive(0, 0, 0);
        for (int k = 0; k < 16; k++) cycle();
        check("pre_reset_busy", int'(busy[0]), 1);
        check("pre_reset_count", int'(cnt0), 2);
        async_reset();
        check("abort_serial", int'(ser[0]), 1);
        check("abort_count", int'(cnt0), 0);
        check("abort_busy", int'(busy[0]), 0);
        drive(0, 1, 'h55);
        cycle();
        cycle();
        drive(0, 0, 0);
        reset = 1'b1;
        nz = 0;
        for (int k = 0; k < 60; k++) begin
            cycle();
            if (!ser[0]) nz++;
        end
        check("no_resume_low_cycles", nz, 0);

        // randomized traffic with occasional asynchronous resets
        for (int n = 0; n < 4000; n++) begin
            for (int i = 0; i < 3; i++) begin
                if ($urandom_range(3) == 0) drive(i, 1, int'($urandom));
                else                        drive(i, 0, 0);
            end
            cycle();
            if ($urandom_range(999) == 0) begin
                async_reset();
                cycle();
                cycle();
                reset = 1'b1;
            end
        end
        for (int i = 0; i < 3; i++) drive(i, 0, 0);
        for (int k = 0; k < 300; k++) cycle();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
